// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit: iterative radix-2 shift-add multiplier and
// restoring divider sharing one datapath, with single-cycle special cases.
module muldiv_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CNT_W = $clog2(XLEN);
  localparam int unsigned PW    = 2 * XLEN;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  SMIN     = {1'b1, {(XLEN-1){1'b0}}};

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e state_q, state_d;

  // hi/lo hold {partial product} or {remainder, dividend/quotient}; md is
  // the multiplicand or divisor magnitude.
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  hi_q, hi_d;
  logic [XLEN-1:0]  lo_q, lo_d;
  logic [XLEN-1:0]  md_q, md_d;
  logic [2:0]       op_q, op_d;
  logic             neg_q, neg_d;
  logic             neg_rem_q, neg_rem_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [XLEN-1:0]  result_q, result_d;

  logic            in_div, in_sgn_a, in_sgn_b, in_a_neg, in_b_neg;
  logic            in_div0, in_ovf, in_special;
  logic [XLEN-1:0] in_a_mag, in_b_mag, in_spec_res;

  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_shift;
  logic [XLEN-1:0] div_diff;
  logic            div_ok;
  logic [XLEN-1:0] it_hi, it_lo;

  logic [PW-1:0]   prod, prod_s;
  logic [XLEN-1:0] quo_s, rem_s, fin_res;

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

  // Decode the incoming request: operand signs, magnitudes, special cases.
  always_comb begin
    in_div   = op[2];
    in_sgn_a = (op != OP_MULHU) && (op != OP_DIVU) && (op != OP_REMU);
    in_sgn_b = (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    in_a_neg = in_sgn_a && a[XLEN-1];
    in_b_neg = in_sgn_b && b[XLEN-1];
    in_a_mag = in_a_neg ? -a : a;
    in_b_mag = in_b_neg ? -b : b;
    in_div0  = in_div && (b == '0);
    in_ovf   = in_div && !op[0] && (a == SMIN) && (b == '1);
    in_special = in_div0 || in_ovf;
    if (in_div0) begin
      in_spec_res = op[1] ? a : '1;
    end else begin
      in_spec_res = op[1] ? '0 : SMIN;
    end
  end

  // One radix-2 step: shift-add for multiply, restoring subtract for divide.
  always_comb begin
    mul_sum   = {1'b0, hi_q} + {1'b0, md_q & {XLEN{lo_q[0]}}};
    div_shift = {hi_q, lo_q[XLEN-1]};
    div_ok    = (div_shift >= {1'b0, md_q});
    div_diff  = div_shift[XLEN-1:0] - md_q;
    if (op_q[2]) begin
      it_hi = div_ok ? div_diff : div_shift[XLEN-1:0];
      it_lo = {lo_q[XLEN-2:0], div_ok};
    end else begin
      it_hi = mul_sum[XLEN:1];
      it_lo = {mul_sum[0], lo_q[XLEN-1:1]};
    end
  end

  // Sign-correct the final step's values and select the requested half.
  always_comb begin
    prod   = {it_hi, it_lo};
    prod_s = neg_q ? -prod : prod;
    quo_s  = neg_q ? -it_lo : it_lo;
    rem_s  = neg_rem_q ? -it_hi : it_hi;
    case (op_q)
      OP_MUL:                       fin_res = prod_s[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fin_res = prod_s[PW-1:XLEN];
      OP_DIV, OP_DIVU:              fin_res = quo_s;
      default:                      fin_res = rem_s;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; flush overrides every transition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = in_special ? S_DONE : S_RUN;
      S_RUN:  if (cnt_q == CNT_LAST) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush) begin
      state_d = S_IDLE;
    end
  end

  // Datapath and output next values.
  always_comb begin
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    md_d      = md_q;
    op_d      = op_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_DONE);
    if (!flush) begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            op_d      = op;
            hi_d      = '0;
            cnt_d     = '0;
            lo_d      = in_div ? in_a_mag : in_b_mag;
            md_d      = in_div ? in_b_mag : in_a_mag;
            neg_d     = in_a_neg ^ in_b_neg;
            neg_rem_d = in_a_neg;
            if (in_special) begin
              result_d = in_spec_res;
            end
          end
        end
        S_RUN: begin
          hi_d  = it_hi;
          lo_d  = it_lo;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            result_d = fin_res;
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      md_q      <= '0;
      op_q      <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
    end else begin
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      md_q      <= md_d;
      op_q      <= op_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      result_q  <= result_d;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: vector table, randomized ops against a behavioral
// model, and hand-written flush / busy-start / reset sequences.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        busy;
  logic        done;
  logic [31:0] result;

  muldiv_unit #(.XLEN(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .flush  (flush),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t        vecs[12];
  logic [31:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_res = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioral reference built on native 64-bit multiply and signed divide.
  function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] x,
                                            input logic [31:0] y);
    logic [63:0]        sx, sy, ux, uy, p;
    logic signed [31:0] xs, ys;
    logic               ovf;
    sx  = {{32{x[31]}}, x};
    sy  = {{32{y[31]}}, y};
    ux  = {32'd0, x};
    uy  = {32'd0, y};
    xs  = x;
    ys  = y;
    ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    case (o)
      3'd0: begin p = sx * sy; return p[31:0]; end
      3'd1: begin p = sx * sy; return p[63:32]; end
      3'd2: begin p = sx * uy; return p[63:32]; end
      3'd3: begin p = ux * uy; return p[63:32]; end
      3'd4: return (y == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(xs / ys);
      3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      3'd6: return (y == 0) ? x : ovf ? 32'd0 : 32'(xs % ys);
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  function automatic int lat_of(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    if (o[2] && ((y == 0) || (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF))) return 1;
    return 33;
  endfunction

  // Result scoreboard: every done pulse pops one expected value.
  always begin
    @(posedge clk);
    #1;
    if (done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=%h expected=no done t=%0t", result, $time);
      end else begin
        chk("result", result, exp_q.pop_front());
      end
    end
  end

  // Issue one op, scramble inputs and poke start while busy, then time it.
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] e, input int lat);
    int edges;
    int busy_cnt;
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    exp_q.push_back(e);
    edges = 0;
    busy_cnt = 0;
    while (1) begin
      @(posedge clk);
      #1;
      edges++;
      if (edges == 1) begin
        start = 1'b0;
        op = 3'($urandom_range(0, 7));
        a = $urandom;
        b = $urandom;
      end
      if (edges == 5) start = 1'b1;
      if (edges == 6) start = 1'b0;
      if (busy) busy_cnt++;
      if (done) break;
      if (edges >= 60) begin
        checks++;
        errors++;
        $display("FAIL done_timeout actual=%0d edges expected=done op=%0d", edges, o);
        break;
      end
    end
    start = 1'b0;
    chk("latency", 32'(edges), 32'(lat));
    chk("busy_cycles", 32'(busy_cnt), 32'(lat));
    @(posedge clk);
    #1;
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("busy_fall", 32'(busy), 32'd0);
    chk("result_hold", result, e);
    last_res = e;
  endtask

  task automatic watch_no_done(input string name, input int cycles);
    int n;
    n = 0;
    repeat (cycles) begin
      @(posedge clk);
      #1;
      if (done) n++;
    end
    chk(name, 32'(n), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  ro;
    logic [31:0] rx, ry;

    vecs[0]  = '{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
    vecs[1]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
    vecs[2]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33};
    vecs[3]  = '{3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 33};
    vecs[4]  = '{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33};
    vecs[5]  = '{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33};
    vecs[6]  = '{3'd5, 32'd100,       32'd7,         32'd14,        33};
    vecs[7]  = '{3'd7, 32'd100,       32'd7,         32'd2,         33};
    vecs[8]  = '{3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF, 1};
    vecs[9]  = '{3'd6, 32'd7,         32'd0,         32'd7,         1};
    vecs[10] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
    vecs[11] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_result", result, 32'd0);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);
    end

    for (int i = 0; i < 16; i++) begin
      ro = 3'($urandom_range(0, 7));
      rx = $urandom;
      ry = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
      if (i == 3) begin ro = 3'd6; rx = 32'h8000_0000; ry = 32'hFFFF_FFFF; end
      if (i == 7) begin ro = 3'd4; rx = 32'h8000_0000; ry = 32'd3; end
      run_op(ro, rx, ry, ref_model(ro, rx, ry), lat_of(ro, rx, ry));
    end

    // Flush a multiply in its tenth RUN cycle.
    @(negedge clk);
    op = 3'd0; a = 32'd3; b = 32'd5; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("flush_busy_before", 32'(busy), 32'd1);
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush_busy", 32'(busy), 32'd0);
    chk("flush_done", 32'(done), 32'd0);
    chk("flush_result", result, last_res);
    watch_no_done("flush_no_done", 40);

    // Flush and start together: request is dropped.
    @(negedge clk);
    op = 3'd5; a = 32'd9; b = 32'd3; start = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    flush = 1'b0;
    chk("flush_start_busy", 32'(busy), 32'd0);
    watch_no_done("flush_start_no_done", 40);
    chk("flush_start_result", result, last_res);

    // Reset in the middle of a signed divide.
    @(negedge clk);
    op = 3'd4; a = 32'hFFFF_FF9C; b = 32'd7; start = 1'b1;
    exp_q.push_back(ref_model(3'd4, 32'hFFFF_FF9C, 32'd7));
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_done", 32'(done), 32'd0);
    chk("rst_mid_result", result, 32'd0);
    exp_q.delete();
    last_res = 32'd0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    watch_no_done("rst_no_done", 40);
    run_op(3'd4, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 33);
    run_op(3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter: XLEN, default 32 (from riscv_pkg), operand/result width.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 start  input  1  request; accepted only when busy=0.
REQ-005 flush  input  1  abort any in-flight operation (pipeline kill).
REQ-006 op  input  3  operation, RV32M funct3 encoding: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-007 a  input  XLEN  rs1 operand (dividend / multiplicand).
REQ-008 b  input  XLEN  rs2 operand (divisor / multiplier).
REQ-009 busy  output  1  high while an accepted operation is in progress (RUN or DONE state).
REQ-010 done  output  1  one-cycle pulse; result valid in that cycle.
REQ-011 result  output  XLEN  operation result; held stable until the next accepted start.

Function
REQ-012 FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-013 IDLE: start=1 and flush=0 at an edge -> latch a, b, op; go to RUN (normal) or DONE (special case, REQ-018/019).
REQ-014 RUN: one radix-2 iteration per cycle, 5-bit counter 0..31; after iteration 31 -> DONE.
REQ-015 DONE: done=1, busy=1 for exactly one cycle -> IDLE.
REQ-016 Normal latency: done high in the cycle beginning 33 edges after the accepting edge (32 RUN + 1 DONE).
REQ-017 Multiply: shift-add on 64-bit product of sign/zero-extended operands; MUL returns low XLEN bits; MULH signed*signed high; MULHSU signed a * unsigned b high; MULHU unsigned high.
REQ-018 Divide by zero (b=0): no RUN; DONE on next edge; DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> a.
REQ-019 Signed overflow (DIV/REM, a=0x80000000, b=0xFFFFFFFF): no RUN; DIV -> 0x80000000; REM -> 0.
REQ-020 Divide otherwise: restoring division on magnitudes; quotient negated iff operand signs differ (DIV); remainder takes sign of a (REM); DIVU/REMU unsigned.
REQ-021 start while busy=1 ignored; no effect on in-flight operation or latched operands.
REQ-022 flush=1 in any state -> IDLE on next edge; done stays 0; result keeps previous value.
REQ-023 flush and start in the same IDLE cycle: flush wins; request not accepted.
REQ-024 Input changes on a/b/op after acceptance do not affect the result.
REQ-025 start accepted in the cycle immediately after done (back-to-back) with no bubble.

Reset
REQ-026 rst_n=0 asynchronously forces IDLE, busy=0, done=0, result=0, counter=0, internal operand registers 0.
REQ-027 Reset asserted mid-operation aborts it; no done pulse after release.
REQ-028 First start accepted at the first rising edge with rst_n=1.

Verification
REQ-029 MUL a=7, b=0xFFFFFFFD -> result 0xFFFFFFEB, done exactly 33 edges after start; busy high 33 cycles.
REQ-030 MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000; MULHSU a=0xFFFFFFFF, b=2 -> 0xFFFFFFFF.
REQ-031 DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2.
REQ-032 DIVU a=5, b=0 -> 0xFFFFFFFF, done 1 edge after start; REM a=7, b=0 -> 7; DIV 0x80000000/0xFFFFFFFF -> 0x80000000 in 1 cycle.
REQ-033 Start MUL, pulse flush at RUN cycle 10 -> busy low next cycle, no done; start during busy -> ignored, original result delivered.
REQ-034 Assert rst_n=0 mid-DIV -> busy/done/result 0 immediately; next start after release completes normally.
